// File: rtl/reg_select_pkg.sv
// Shared types and field-layout helpers for the register-select / encode unit.
// Field offsets are computed from the instance widths so every parameter set decodes consistently.
package reg_select_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL_A = 3'd1,
        ST_SEL_B = 3'd2,
        ST_SEL_C = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    localparam logic [1:0] FIELD_A = 2'd0;
    localparam logic [1:0] FIELD_B = 2'd1;
    localparam logic [1:0] FIELD_C = 2'd2;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_OPCODE_W = 5;
    localparam int DEF_SEL_W    = 4;

    // ra, rb and rc sit back to back directly below the opcode.
    function automatic int field_lsb(input int data_w, input int opcode_w,
                                     input int sel_w, input logic [1:0] field);
        return data_w - opcode_w - (int'(field) + 1) * sel_w;
    endfunction

    localparam int RA_LSB = field_lsb(DEF_DATA_W, DEF_OPCODE_W, DEF_SEL_W, FIELD_A);
    localparam int RB_LSB = field_lsb(DEF_DATA_W, DEF_OPCODE_W, DEF_SEL_W, FIELD_B);
    localparam int RC_LSB = field_lsb(DEF_DATA_W, DEF_OPCODE_W, DEF_SEL_W, FIELD_C);

endpackage

// File: rtl/decode_onehot.sv
// Binary register index to one-hot strobe vector, gated by an enable.
module decode_onehot #(
    parameter int SEL_W    = 4,
    parameter int NUM_REGS = 16
) (
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_onehot[i] = i_en && (i_sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/reg_select_encode.sv
// Instruction register, ra/rb/rc field decode to one-hot register strobes, constant
// sign extension and a small operand sequencer that walks the selected fields one per handshake.
module reg_select_encode
    import reg_select_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OPCODE_W = 5,
    parameter int CONST_W  = 19
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [DATA_W-1:0]   ir_bus,
    input  logic                ir_in,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                r_in,
    input  logic                r_out,
    input  logic                ba_out,
    input  logic                seq_start,
    input  logic [2:0]          seq_mask,
    input  logic                seq_ready,
    output logic [NUM_REGS-1:0] r_enable,
    output logic [NUM_REGS-1:0] r_out_sel,
    output logic                zero_out,
    output logic [DATA_W-1:0]   c_sign,
    output logic                seq_valid,
    output logic [1:0]          seq_field,
    output logic                seq_done,
    output logic                busy,
    output logic [2:0]          o_dbg_state
);

    localparam int SEL_W = $clog2(NUM_REGS);
    localparam int A_LSB = field_lsb(DATA_W, OPCODE_W, SEL_W, FIELD_A);
    localparam int B_LSB = field_lsb(DATA_W, OPCODE_W, SEL_W, FIELD_B);
    localparam int C_LSB = field_lsb(DATA_W, OPCODE_W, SEL_W, FIELD_C);

    // Sequencer handshake: an operand transfers on a rising edge where seq_valid and
    // seq_ready are both high; while seq_ready is low every sequencer output holds.
    logic [DATA_W-1:0] r_ir;
    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [2:0]        r_mask;
    logic              r_ba;

    logic [SEL_W-1:0]    w_ra, w_rb, w_rc;
    logic [SEL_W-1:0]    w_dir_sel, w_seq_sel;
    logic                w_gr_any;
    logic                w_start_ok;
    logic [NUM_REGS-1:0] w_dir_onehot, w_seq_onehot;
    logic                w_dir_zero, w_seq_zero;

    assign w_ra = r_ir[A_LSB +: SEL_W];
    assign w_rb = r_ir[B_LSB +: SEL_W];
    assign w_rc = r_ir[C_LSB +: SEL_W];

    assign c_sign = {{(DATA_W-CONST_W){r_ir[CONST_W-1]}}, r_ir[CONST_W-1:0]};
    assign o_dbg_state = r_state;

    assign w_start_ok = (r_state == ST_IDLE) && seq_start && (seq_mask != 3'b000);

    // State register, IR and captured sequence controls.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
            r_mask  <= '0;
            r_ba    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (ir_in && (r_state == ST_IDLE)) begin
                r_ir <= ir_bus;
            end
            if (w_start_ok) begin
                r_mask <= seq_mask;
                r_ba   <= ba_out;
            end
        end
    end

    // Next-state logic: always advance to the next set field above the current one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    if (seq_mask[0])      w_next = ST_SEL_A;
                    else if (seq_mask[1]) w_next = ST_SEL_B;
                    else                  w_next = ST_SEL_C;
                end
            end
            ST_SEL_A: begin
                if (seq_ready) begin
                    if (r_mask[1])      w_next = ST_SEL_B;
                    else if (r_mask[2]) w_next = ST_SEL_C;
                    else                w_next = ST_DONE;
                end
            end
            ST_SEL_B: begin
                if (seq_ready) w_next = r_mask[2] ? ST_SEL_C : ST_DONE;
            end
            ST_SEL_C: begin
                if (seq_ready) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Moore outputs of the sequencer.
    always_comb begin
        busy      = (r_state != ST_IDLE);
        seq_valid = 1'b0;
        seq_field = FIELD_A;
        seq_done  = 1'b0;
        w_seq_sel = '0;
        case (r_state)
            ST_SEL_A: begin
                seq_valid = 1'b1;
                seq_field = FIELD_A;
                w_seq_sel = w_ra;
            end
            ST_SEL_B: begin
                seq_valid = 1'b1;
                seq_field = FIELD_B;
                w_seq_sel = w_rb;
            end
            ST_SEL_C: begin
                seq_valid = 1'b1;
                seq_field = FIELD_C;
                w_seq_sel = w_rc;
            end
            ST_DONE: seq_done = 1'b1;
            default: ;
        endcase
    end

    // Direct path: strict a > b > c priority, never a merge of fields.
    assign w_gr_any  = gra | grb | grc;
    assign w_dir_sel = gra ? w_ra : (grb ? w_rb : w_rc);

    decode_onehot #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dec_direct (
        .i_sel    (w_dir_sel),
        .i_en     (w_gr_any),
        .o_onehot (w_dir_onehot)
    );

    decode_onehot #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dec_seq (
        .i_sel    (w_seq_sel),
        .i_en     (seq_valid),
        .o_onehot (w_seq_onehot)
    );

    // R0 under ba_out reads as zero: no register drives the bus.
    assign w_dir_zero = w_gr_any && ba_out && (w_dir_sel == '0);
    assign w_seq_zero = seq_valid && r_ba && (w_seq_sel == '0);

    always_comb begin
        r_enable  = '0;
        r_out_sel = '0;
        zero_out  = 1'b0;
        if (busy) begin
            zero_out = w_seq_zero;
            if (!w_seq_zero) r_out_sel = w_seq_onehot;
        end else begin
            zero_out = w_dir_zero;
            if (r_in) r_enable = w_dir_onehot;
            if ((r_out || ba_out) && !w_dir_zero) r_out_sel = w_dir_onehot;
        end
    end

endmodule

// File: tb/tb_reg_select_encode.sv
// Bench for reg_select_encode: direct-mode vector table, randomized direct and sequencer
// traffic against a reference model, and hand-written multi-cycle corner sequences.
module tb_reg_select_encode;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir_bus;
    logic        ir_in, gra, grb, grc, r_in, r_out, ba_out;
    logic        seq_start, seq_ready;
    logic [2:0]  seq_mask;
    logic [15:0] r_enable, r_out_sel;
    logic        zero_out, seq_valid, seq_done, busy;
    logic [31:0] c_sign;
    logic [1:0]  seq_field;
    logic [2:0]  dbg_state;

    int n_chk = 0;
    int n_err = 0;

    reg_select_encode dut (
        .clock(clock), .clear(clear), .ir_bus(ir_bus), .ir_in(ir_in),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .seq_start(seq_start), .seq_mask(seq_mask), .seq_ready(seq_ready),
        .r_enable(r_enable), .r_out_sel(r_out_sel), .zero_out(zero_out), .c_sign(c_sign),
        .seq_valid(seq_valid), .seq_field(seq_field), .seq_done(seq_done), .busy(busy),
        .o_dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ir;
        logic [2:0]  gr;     // {grc, grb, gra}
        logic [2:0]  strb;   // {ba_out, r_out, r_in}
        logic [15:0] exp_en;
        logic [15:0] exp_sel;
        logic        exp_zero;
        logic [31:0] exp_c;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] v);
        ir_bus = v;
        ir_in  = 1'b1;
        tick();
        ir_in  = 1'b0;
    endtask

    // Reference model: fields counted from the top of a 32-bit word below a 5-bit opcode.
    function automatic int reg_of(input logic [31:0] ir, input int f);
        return int'((ir >> (23 - 4 * f)) & 32'hF);
    endfunction

    function automatic logic [31:0] csign_of(input logic [31:0] ir);
        logic [31:0] v;
        v = ir & 32'h0007_FFFF;
        if (ir[18]) v = v | 32'hFFF8_0000;
        return v;
    endfunction

    task automatic direct_model(input logic [31:0] ir, input logic [2:0] gr, input logic [2:0] strb,
                                output logic [15:0] en, output logic [15:0] sel, output logic zero);
        int f;
        logic [15:0] oh;
        en = 0; sel = 0; zero = 0;
        if (gr != 0) begin
            f  = gr[0] ? reg_of(ir, 0) : (gr[1] ? reg_of(ir, 1) : reg_of(ir, 2));
            oh = 16'(1) << f;
            if (strb[0]) en = oh;
            if (strb[2] && f == 0) zero = 1;
            else if (strb[1] || strb[2]) sel = oh;
        end
    endtask

    task automatic apply_direct(input logic [2:0] gr, input logic [2:0] strb);
        {grc, grb, gra}      = gr;
        {ba_out, r_out, r_in} = strb;
        #1;
    endtask

    task automatic idle_inputs();
        {gra, grb, grc, r_in, r_out, ba_out} = '0;
        seq_start = 0; seq_mask = 0; seq_ready = 0; ir_in = 0; ir_bus = 0;
    endtask

    // Run one full sequence with random stalls and check every cycle against the field list.
    task automatic run_sequence(input logic [31:0] ir, input logic [2:0] mask, input logic ba);
        int fq[$];
        int expected_reg;
        logic acc;
        for (int k = 0; k < 3; k++) if (mask[k]) fq.push_back(k);
        load_ir(ir);
        seq_mask = mask; ba_out = ba; seq_start = 1;
        tick();
        seq_start = 0;
        ba_out = $urandom_range(0, 1);
        gra = 1; r_in = 1;
        foreach (fq[i]) begin
            acc = 0;
            expected_reg = reg_of(ir, fq[i]);
            for (int s = 0; s < 4 && !acc; s++) begin
                chk("rnd_seq_valid", seq_valid, 1);
                chk("rnd_seq_field", seq_field, fq[i]);
                chk("rnd_seq_sel", r_out_sel, (ba && expected_reg == 0) ? 0 : (32'd1 << expected_reg));
                chk("rnd_seq_zero", zero_out, ba && expected_reg == 0);
                chk("rnd_seq_en", r_enable, 0);
                seq_ready = (s == 3) ? 1'b1 : 1'($urandom_range(0, 1));
                acc = seq_ready;
                tick();
            end
        end
        seq_ready = 0;
        chk("rnd_seq_done", seq_done, 1);
        chk("rnd_seq_done_valid", seq_valid, 0);
        tick();
        chk("rnd_seq_idle", busy, 0);
        chk("rnd_seq_done_clr", seq_done, 0);
        idle_inputs();
    endtask

    initial begin
        logic [15:0] e_en, e_sel;
        logic        e_zero;
        logic [31:0] rir;
        logic [2:0]  rgr, rstrb;

        vecs[0] = '{32'h1A98_0000, 3'b001, 3'b001, 16'h0020, 16'h0000, 1'b0, 32'h0000_0000};
        vecs[1] = '{32'h1A98_0000, 3'b010, 3'b010, 16'h0000, 16'h0008, 1'b0, 32'h0000_0000};
        vecs[2] = '{32'h1A98_0000, 3'b100, 3'b100, 16'h0000, 16'h0000, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'h1A98_0000, 3'b011, 3'b010, 16'h0000, 16'h0020, 1'b0, 32'h0000_0000};
        vecs[4] = '{32'h1A98_0000, 3'b001, 3'b100, 16'h0000, 16'h0020, 1'b0, 32'h0000_0000};
        vecs[5] = '{32'h1A98_0000, 3'b000, 3'b111, 16'h0000, 16'h0000, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'h1A98_0000, 3'b111, 3'b011, 16'h0020, 16'h0020, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h1A98_0000, 3'b100, 3'b111, 16'h0001, 16'h0000, 1'b1, 32'h0000_0000};
        vecs[8] = '{32'h0007_FFFF, 3'b000, 3'b000, 16'h0000, 16'h0000, 1'b0, 32'hFFFF_FFFF};
        vecs[9] = '{32'h0003_FFFF, 3'b000, 3'b000, 16'h0000, 16'h0000, 1'b0, 32'h0003_FFFF};

        idle_inputs();
        clear = 0;
        ir_bus = 32'hFFFF_FFFF; ir_in = 1;
        tick(); tick();
        ir_in = 0;
        chk("rst_c_sign", c_sign, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", seq_valid, 0);
        chk("rst_done", seq_done, 0);
        clear = 1;
        tick();

        foreach (vecs[i]) begin
            load_ir(vecs[i].ir);
            apply_direct(vecs[i].gr, vecs[i].strb);
            chk($sformatf("vec%0d_en", i), r_enable, vecs[i].exp_en);
            chk($sformatf("vec%0d_sel", i), r_out_sel, vecs[i].exp_sel);
            chk($sformatf("vec%0d_zero", i), zero_out, vecs[i].exp_zero);
            chk($sformatf("vec%0d_csign", i), c_sign, vecs[i].exp_c);
            idle_inputs();
        end

        for (int n = 0; n < 40; n++) begin
            rir = $urandom;
            if (n % 4 == 0) rir[26:15] = '0;
            rgr = 3'($urandom_range(0, 7));
            rstrb = 3'($urandom_range(0, 7));
            load_ir(rir);
            apply_direct(rgr, rstrb);
            direct_model(rir, rgr, rstrb, e_en, e_sel, e_zero);
            chk("rnd_dir_en", r_enable, e_en);
            chk("rnd_dir_sel", r_out_sel, e_sel);
            chk("rnd_dir_zero", zero_out, e_zero);
            chk("rnd_dir_csign", c_sign, csign_of(rir));
            idle_inputs();
        end

        for (int n = 0; n < 20; n++) begin
            rir = $urandom;
            if (n % 3 == 0) rir[26:15] = '0;
            run_sequence(rir, 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
        end

        // Mask 101 with ready held high.
        load_ir(32'h1A9C_8000);
        seq_mask = 3'b101; seq_start = 1; seq_ready = 1;
        tick(); seq_start = 0;
        chk("s101_c1_field", seq_field, 0);
        chk("s101_c1_sel", r_out_sel, 16'h0020);
        tick();
        chk("s101_c2_field", seq_field, 2);
        chk("s101_c2_sel", r_out_sel, 16'h0200);
        tick();
        chk("s101_c3_done", seq_done, 1);
        tick();
        chk("s101_c4_busy", busy, 0);
        idle_inputs();

        // Mask 010 with four stalled cycles and an ignored IR load.
        seq_mask = 3'b010; seq_start = 1;
        tick(); seq_start = 0;
        ir_bus = 32'hFFFF_FFFF; ir_in = 1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_sel", r_out_sel, 16'h0008);
            chk("stall_done", seq_done, 0);
            if (c == 4) seq_ready = 1;
            tick();
            ir_in = 0;
        end
        seq_ready = 0;
        chk("stall_done_pulse", seq_done, 1);
        tick();
        chk("stall_ir_kept", c_sign, csign_of(32'h1A9C_8000));
        idle_inputs();

        // Reset while in SEL_B.
        load_ir(32'h1A9C_8000);
        seq_mask = 3'b111; seq_start = 1; seq_ready = 1;
        tick(); seq_start = 0;
        tick(); seq_ready = 0;
        chk("rstmid_in_b", seq_field, 1);
        clear = 0;
        tick(); clear = 1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_valid", seq_valid, 0);
        chk("rstmid_sel", r_out_sel, 0);
        chk("rstmid_csign", c_sign, 0);
        chk("rstmid_done", seq_done, 0);
        tick();
        chk("rstmid_no_pulse", seq_done, 0);

        // Mask 0 is ignored.
        load_ir(32'h1A9C_8000);
        seq_mask = 3'b000; seq_start = 1;
        tick(); seq_start = 0;
        chk("mask0_busy", busy, 0);

        // A second start while busy must not restart the sequence.
        seq_mask = 3'b001; seq_start = 1;
        tick();
        seq_mask = 3'b100;
        tick(); seq_start = 0;
        chk("restart_field", seq_field, 0);
        chk("restart_sel", r_out_sel, 16'h0020);
        seq_ready = 1;
        tick(); seq_ready = 0;
        chk("restart_done", seq_done, 1);
        tick();
        chk("restart_idle", busy, 0);
        idle_inputs();

        // IR load and start on the same edge use the new IR.
        ir_bus = 32'h0180_0000; ir_in = 1; seq_mask = 3'b001; seq_start = 1;
        tick(); ir_in = 0; seq_start = 0;
        chk("same_edge_sel", r_out_sel, 16'h0008);
        seq_ready = 1;
        tick(); tick();
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
